// File: rtl/cpu_params_pkg.sv
// Shared CPU sizing parameters and the write-back queue entry type.
package cpu_params_pkg;

  localparam int unsigned MAX_GPR   = 32;
  localparam int unsigned GPR_ASZ   = $clog2(MAX_GPR);
  localparam int unsigned RSZ       = 32;
  localparam int unsigned WBQ_DEPTH = 4;

  typedef struct packed {
    logic [GPR_ASZ-1:0] addr;
    logic [RSZ-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/rbus_intf.sv
// GPR register-file write port shared by write-back producers and checkers.
interface RBUS_intf;
  import cpu_params_pkg::*;

  logic               Rd_wr;
  logic [GPR_ASZ-1:0] Rd_addr;
  logic [RSZ-1:0]     Rd_data;

  modport master (output Rd_wr, output Rd_addr, output Rd_data);
  modport slave  (input Rd_wr, input Rd_addr, input Rd_data);
endinterface

// File: rtl/wbq_fwd_lookup.sv
// Pending-write mask and youngest-match forwarding over queue entries plus the Rd stage.
module wbq_fwd_lookup
  import cpu_params_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  wbq_entry_t [Depth-1:0] entries_i,
  input  logic [Depth-1:0]       valid_i,
  input  logic [PtrW-1:0]        rptr_i,
  input  logic                   rd_wr_i,
  input  logic [GPR_ASZ-1:0]     rd_addr_i,
  input  logic [RSZ-1:0]         rd_data_i,
  input  logic [GPR_ASZ-1:0]     fwd_addr_i,
  output logic                   fwd_hit_o,
  output logic [RSZ-1:0]         fwd_data_o,
  output logic [MAX_GPR-1:0]     pend_mask_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match wins; the Rd stage is older than any entry.
  always_comb begin
    fwd_hit_o   = 1'b0;
    fwd_data_o  = '0;
    pend_mask_o = '0;
    idx         = rptr_i;
    if (rd_wr_i) begin
      pend_mask_o[rd_addr_i] = 1'b1;
      if (rd_addr_i == fwd_addr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = rd_data_i;
      end
    end
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = rptr_i + PtrW'(k);
      if (valid_i[idx]) begin
        pend_mask_o[entries_i[idx].addr] = 1'b1;
        if (entries_i[idx].addr == fwd_addr_i) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = entries_i[idx].data;
        end
      end
    end
    if (fwd_addr_i == '0) begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
    end
  end

endmodule

// File: rtl/gpr_wb_queue.sv
// FIFO of GPR write-backs draining one per cycle into a registered GPR write port.
module gpr_wb_queue
  import cpu_params_pkg::GPR_ASZ, cpu_params_pkg::RSZ, cpu_params_pkg::MAX_GPR,
         cpu_params_pkg::wbq_entry_t;
#(
  parameter int unsigned WBQ_DEPTH = cpu_params_pkg::WBQ_DEPTH
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               wb_valid,
  input  logic [GPR_ASZ-1:0] wb_addr,
  input  logic [RSZ-1:0]     wb_data,
  output logic               wb_ready,
  input  logic               flush_in,
  input  logic [GPR_ASZ-1:0] fwd_addr,
  output logic               fwd_hit,
  output logic [RSZ-1:0]     fwd_data,
  output logic [MAX_GPR-1:0] pend_mask,
  RBUS_intf.master           gpr_bus
);

  localparam int unsigned PtrW = $clog2(WBQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wbq_entry_t [WBQ_DEPTH-1:0] entries_q, entries_d;
  logic [WBQ_DEPTH-1:0]       valid_q, valid_d;
  logic [PtrW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       rd_wr_q, rd_wr_d;
  logic [GPR_ASZ-1:0]         rd_addr_q, rd_addr_d;
  logic [RSZ-1:0]             rd_data_q, rd_data_d;

  logic               push, pop;
  logic               lk_hit;
  logic [RSZ-1:0]     lk_data;
  logic [MAX_GPR-1:0] lk_mask;

  assign wb_ready = reset_in && (count_q < CntW'(WBQ_DEPTH));
  // Writes to r0 complete the handshake but never occupy an entry.
  assign push     = wb_valid && wb_ready && !flush_in && (wb_addr != '0);
  assign pop      = (count_q != '0) && !flush_in;

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rd_wr_d   = pop;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (flush_in) begin
      valid_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rd_addr_d       = entries_q[rptr_q].addr;
        rd_data_d       = entries_q[rptr_q].data;
        valid_d[rptr_q] = 1'b0;
        rptr_d          = rptr_q + 1'b1;
      end
      if (push) begin
        entries_d[wptr_q].addr = wb_addr;
        entries_d[wptr_q].data = wb_data;
        valid_d[wptr_q]        = 1'b1;
        wptr_d                 = wptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      entries_q <= '0;
      valid_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_wr_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_wr_q   <= rd_wr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign gpr_bus.Rd_wr   = rd_wr_q;
  assign gpr_bus.Rd_addr = rd_addr_q;
  assign gpr_bus.Rd_data = rd_data_q;

  wbq_fwd_lookup #(
    .Depth (WBQ_DEPTH)
  ) u_fwd_lookup (
    .entries_i   (entries_q),
    .valid_i     (valid_q),
    .rptr_i      (rptr_q),
    .rd_wr_i     (rd_wr_q),
    .rd_addr_i   (rd_addr_q),
    .rd_data_i   (rd_data_q),
    .fwd_addr_i  (fwd_addr),
    .fwd_hit_o   (lk_hit),
    .fwd_data_o  (lk_data),
    .pend_mask_o (lk_mask)
  );

  // Lookup state is stale until the first reset edge, so mask it while reset is held.
  assign fwd_hit   = reset_in && lk_hit;
  assign fwd_data  = reset_in ? lk_data : '0;
  assign pend_mask = reset_in ? lk_mask : '0;

endmodule

// File: doc/gpr_wb_queue.md
GPR_WB_QUEUE -- requirements
Module: gpr_wb_queue

Interface
REQ-001 Parameter WBQ_DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 clk_in  input  1  sole clock, rising edge.
REQ-003 reset_in  input  1  synchronous reset, active-low.
REQ-004 wb_valid  input  1  producer has a write-back request.
REQ-005 wb_addr  input  GPR_ASZ  destination GPR.
REQ-006 wb_data  input  RSZ  write-back value.
REQ-007 wb_ready  output  1  queue accepts a request this cycle.
REQ-008 flush_in  input  1  discard all queued, not-yet-driven writes.
REQ-009 fwd_addr  input  GPR_ASZ  forwarding lookup address.
REQ-010 fwd_hit  output  1  a pending write to fwd_addr exists.
REQ-011 fwd_data  output  RSZ  data of the youngest pending write to fwd_addr.
REQ-012 pend_mask  output  MAX_GPR  bit n = pending write to GPR n.
REQ-013 gpr_bus  RBUS_intf.master  Rd_wr/Rd_addr/Rd_data, the GPR write port.

Function
REQ-014 Handshake: request accepted on a rising edge with wb_valid & wb_ready & !flush_in.
REQ-015 wb_ready = (count < WBQ_DEPTH), from registered count only; no same-cycle pass-through when full.
REQ-016 Accepted requests with wb_addr==0 are consumed and discarded: no entry, no Rd_wr, no pend_mask bit.
REQ-017 Queue is FIFO; entries leave in acceptance order.
REQ-018 Pop: on every edge with count>0 and !flush_in, head loads the Rd output registers; Rd_wr=1 for exactly the next cycle.
REQ-019 Rd_wr/Rd_addr/Rd_data are registered outputs; Rd_wr=0 in any cycle with no pop on the previous edge.
REQ-020 Latency: accepted in cycle C with empty queue -> Rd_wr=1 in cycle C+2; steady-state throughput 1 write/cycle.
REQ-021 Simultaneous push and pop: both take effect; count unchanged.
REQ-022 count is $clog2(WBQ_DEPTH)+1 bits; read/write pointers wrap modulo WBQ_DEPTH.
REQ-023 Flush in cycle C: all queue entries and any push in C are dropped; no pop on that edge; count=0 after the edge; Rd_wr=0 in C+1; a write already on Rd in C completes.
REQ-024 pend_mask and fwd_* cover all valid queue entries plus the Rd output stage when Rd_wr=1; combinational from registered state.
REQ-025 fwd_hit=0 and fwd_data='0 when no match or fwd_addr==0; multiple matches select the youngest (Rd stage oldest).
REQ-026 Rd_wr never asserts with X on Rd_addr/Rd_data.

Reset
REQ-027 While reset_in==0 at an edge: count=0, pointers=0, Rd_wr=0, Rd_addr='0, Rd_data='0, all entry valids cleared.
REQ-028 During reset: wb_ready=0, pend_mask='0, fwd_hit=0; requests are not accepted.
REQ-029 Reset mid-operation discards all pending writes; no Rd_wr until a new request after reset release.

Structure
REQ-030 MAX_GPR, GPR_ASZ, RSZ from cpu_params_pkg; WBQ_DEPTH default added to cpu_params_pkg.
REQ-031 Entry typedef (addr, data) defined in cpu_params_pkg as wbq_entry_t.
REQ-032 One sub-module natural: wbq_fwd_lookup (youngest-match search over entries + Rd stage); storage/pointers inline.
REQ-033 Binds cleanly to the existing GPR assertion checker through gpr_bus.

Verification
REQ-034 Push addr=5 data=0xDEADBEEF into empty queue in cycle 1 -> Rd_wr=1, Rd_addr=5, Rd_data=0xDEADBEEF in cycle 3 only.
REQ-035 Push 5 back-to-back (addr 1..5) with DEPTH=4 and no pop-stall -> wb_ready never drops, Rd_wr high 5 consecutive cycles, order 1..5.
REQ-036 Push addr=7 data=0x1 then addr=7 data=0x2 -> fwd_addr=7 gives fwd_hit=1, fwd_data=0x2; pend_mask[7]=1 until second Rd_wr cycle ends.
REQ-037 Push addr=0 data=0x55 -> accepted, no Rd_wr, pend_mask stays 0, fwd_hit=0 for fwd_addr=0.
REQ-038 Fill 3 entries, assert flush_in with concurrent push -> count 0, Rd_wr=0 next cycle, pend_mask=0, wb_ready=1.
REQ-039 Drop reset_in low with 2 entries queued -> Rd_wr=0, wb_ready=0, pend_mask=0 during reset; no writes after release.
